// File: rtl/occupancy_ctrl.sv
// ---------------------------------------------------------------------------
// occupancy_ctrl
//
// Room occupancy counter driven by pairs of light barriers. Each doorway has
// an outer barrier (x1) and an inner barrier (x2). Breaking x1 and then x2 is
// an entry. Breaking x2 and then x1 is an exit. Each door has its own small
// FSM. All doors feed one saturating occupancy counter. The room lamp stays
// on while the room is occupied and for OFF_DELAY cycles after it empties.
//
// Parameters
//   DOORS      number of doorways (1..8)
//   CNT_W      occupancy counter width
//   MAX_OCC    saturation ceiling (1..2^CNT_W-1)
//   OFF_DELAY  lamp hold cycles after the room empties (0 allowed)
//   TIMEOUT    cycles a half-crossed door may stay pending (>= 1)
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   clr        synchronous clear of occupancy; overrides all events
//   x1, x2     outer / inner barrier per door, high = beam broken
//   lamp       room light
//   count      current occupancy
//   full       count == MAX_OCC
//   empty      count == 0
//   enter_evt  one-cycle pulse per door when an entry is counted
//   exit_evt   one-cycle pulse per door when an exit is counted
//   ovf        one-cycle pulse: an entry was rejected at the ceiling
//   unf        one-cycle pulse: an exit was rejected at zero
// ---------------------------------------------------------------------------
module occupancy_ctrl #(
  parameter int DOORS     = 2,
  parameter int CNT_W     = 8,
  parameter int MAX_OCC   = 200,
  parameter int OFF_DELAY = 16,
  parameter int TIMEOUT   = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [DOORS-1:0] x1,
  input  logic [DOORS-1:0] x2,
  output logic             lamp,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty,
  output logic [DOORS-1:0] enter_evt,
  output logic [DOORS-1:0] exit_evt,
  output logic             ovf,
  output logic             unf
);

  // Door FSM states
  localparam logic [1:0] IDLE  = 2'd0;  // no crossing in progress
  localparam logic [1:0] IN_A  = 2'd1;  // outer beam broken first
  localparam logic [1:0] OUT_B = 2'd2;  // inner beam broken first
  localparam logic [1:0] WAIT  = 2'd3;  // wait for both beams clear

  // The pending timer holds 0..TIMEOUT-1
  localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  // The hold counter holds 0..OFF_DELAY
  localparam int HOLD_W = (OFF_DELAY > 0) ? $clog2(OFF_DELAY + 1) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(OFF_DELAY);

  // Signed headroom for count minus up to 8 exits plus up to 8 entries
  localparam int SUM_W = CNT_W + 5;
  localparam logic signed [SUM_W-1:0] MAX_S   = SUM_W'(MAX_OCC);
  localparam logic        [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OCC);

  // Number of set bits in a door vector (DOORS <= 8, so 4 bits suffice)
  function automatic logic [3:0] popcnt(input logic [DOORS-1:0] v);
    logic [3:0] n;
    n = '0;
    for (int k = 0; k < DOORS; k++) begin
      n = n + {3'b000, v[k]};
    end
    return n;
  endfunction

  // Lower clamp: negative results become zero
  function automatic logic signed [SUM_W-1:0] sat_floor(
    input logic signed [SUM_W-1:0] v
  );
    if (v[SUM_W-1]) begin
      return '0;
    end
    return v;
  endfunction

  // Upper clamp: results above the ceiling become MAX_OCC
  function automatic logic signed [SUM_W-1:0] sat_ceil(
    input logic signed [SUM_W-1:0] v
  );
    if (v > MAX_S) begin
      return MAX_S;
    end
    return v;
  endfunction

  logic [1:0]        st      [DOORS];
  logic [1:0]        st_nxt  [DOORS];
  logic [TMR_W-1:0]  tmr     [DOORS];
  logic [TMR_W-1:0]  tmr_nxt [DOORS];
  logic [DOORS-1:0]  ent_nxt;
  logic [DOORS-1:0]  ext_nxt;

  logic [HOLD_W-1:0] hold;
  logic [HOLD_W-1:0] hold_nxt;

  logic [3:0]               n_ent;
  logic [3:0]               n_ext;
  logic signed [SUM_W-1:0]  cur_s;
  logic signed [SUM_W-1:0]  drained_s;
  logic signed [SUM_W-1:0]  sum_s;
  logic signed [SUM_W-1:0]  filled_s;
  logic [CNT_W-1:0]         cnt_nxt;
  logic                     ovf_nxt;
  logic                     unf_nxt;
  logic                     lamp_nxt;

  // Stage: per-door crossing detection
  always_comb begin
    ent_nxt = '0;
    ext_nxt = '0;
    for (int i = 0; i < DOORS; i++) begin
      st_nxt[i]  = st[i];
      tmr_nxt[i] = '0;
      case (st[i])
        IDLE: begin
          if (x1[i] && !x2[i]) begin
            st_nxt[i] = IN_A;
          end else if (x2[i] && !x1[i]) begin
            st_nxt[i] = OUT_B;
          end
        end
        IN_A: begin
          // A completed crossing wins over a timeout on the same edge
          if (x2[i]) begin
            st_nxt[i]  = WAIT;
            ent_nxt[i] = 1'b1;
          end else if (!x1[i]) begin
            st_nxt[i] = IDLE;
          end else if (tmr[i] == TMR_LAST) begin
            st_nxt[i] = WAIT;
          end else begin
            tmr_nxt[i] = tmr[i] + TMR_W'(1);
          end
        end
        OUT_B: begin
          if (x1[i]) begin
            st_nxt[i]  = WAIT;
            ext_nxt[i] = 1'b1;
          end else if (!x2[i]) begin
            st_nxt[i] = IDLE;
          end else if (tmr[i] == TMR_LAST) begin
            st_nxt[i] = WAIT;
          end else begin
            tmr_nxt[i] = tmr[i] + TMR_W'(1);
          end
        end
        default: begin
          if (!x1[i] && !x2[i]) begin
            st_nxt[i] = IDLE;
          end
        end
      endcase
      // Clear parks every door in WAIT so a half-done crossing cannot
      // complete until its beams have been seen clear.
      if (clr) begin
        st_nxt[i]  = WAIT;
        tmr_nxt[i] = '0;
      end
    end
    if (clr) begin
      ent_nxt = '0;
      ext_nxt = '0;
    end
  end

  // Stage: occupancy update, exits applied before entries, then clamped
  always_comb begin
    n_ent     = popcnt(ent_nxt);
    n_ext     = popcnt(ext_nxt);
    cur_s     = $signed({{(SUM_W-CNT_W){1'b0}}, count});
    drained_s = cur_s - $signed({{(SUM_W-4){1'b0}}, n_ext});
    unf_nxt   = drained_s[SUM_W-1];
    sum_s     = sat_floor(drained_s) + $signed({{(SUM_W-4){1'b0}}, n_ent});
    ovf_nxt   = (sum_s > MAX_S);
    filled_s  = sat_ceil(sum_s);
    cnt_nxt   = filled_s[CNT_W-1:0];
    if (clr) begin
      cnt_nxt = '0;
      ovf_nxt = 1'b0;
      unf_nxt = 1'b0;
    end

    // The hold counter only runs while the room is empty; it is armed by
    // the falling transition of count, not by count merely being zero.
    if (clr || (cnt_nxt != '0)) begin
      hold_nxt = '0;
    end else if (count != '0) begin
      hold_nxt = HOLD_LOAD;
    end else if (hold != '0) begin
      hold_nxt = hold - HOLD_W'(1);
    end else begin
      hold_nxt = '0;
    end

    lamp_nxt = (cnt_nxt != '0) || (hold_nxt != '0);
  end

  // Stage: registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DOORS; i++) begin
        st[i]  <= IDLE;
        tmr[i] <= '0;
      end
      count     <= '0;
      full      <= 1'b0;
      empty     <= 1'b1;
      lamp      <= 1'b0;
      hold      <= '0;
      enter_evt <= '0;
      exit_evt  <= '0;
      ovf       <= 1'b0;
      unf       <= 1'b0;
    end else begin
      for (int i = 0; i < DOORS; i++) begin
        st[i]  <= st_nxt[i];
        tmr[i] <= tmr_nxt[i];
      end
      count     <= cnt_nxt;
      full      <= (cnt_nxt == MAX_CNT);
      empty     <= (cnt_nxt == '0);
      lamp      <= lamp_nxt;
      hold      <= hold_nxt;
      enter_evt <= ent_nxt;
      exit_evt  <= ext_nxt;
      ovf       <= ovf_nxt;
      unf       <= unf_nxt;
    end
  end

endmodule

// File: tb/tb_occupancy_ctrl.sv
// ---------------------------------------------------------------------------
// tb_occupancy_ctrl
//
// Self-checking bench for occupancy_ctrl with DOORS=2, CNT_W=4, MAX_OCC=3,
// OFF_DELAY=3, TIMEOUT=8. A behavioural room model tracks each door as a
// pending direction with an age, plus a lock flag, and tracks the lamp as
// "edges since the room last emptied". Every cycle, the outputs are compared
// against this model on the falling clock edge. Directed scenarios add
// literal expectations. A randomized phase then toggles the barriers, clr
// and rst.
// ---------------------------------------------------------------------------
module tb_occupancy_ctrl;

  localparam int DOORS     = 2;
  localparam int CNT_W     = 4;
  localparam int MAX_OCC   = 3;
  localparam int OFF_DELAY = 3;
  localparam int TIMEOUT   = 8;
  localparam int BIG       = 1 << 20;

  logic             clk = 1'b0;
  logic             rst;
  logic             clr;
  logic [DOORS-1:0] x1;
  logic [DOORS-1:0] x2;
  logic             lamp;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             empty;
  logic [DOORS-1:0] enter_evt;
  logic [DOORS-1:0] exit_evt;
  logic             ovf;
  logic             unf;

  int errors = 0;
  int checks = 0;

  occupancy_ctrl #(
    .DOORS    (DOORS),
    .CNT_W    (CNT_W),
    .MAX_OCC  (MAX_OCC),
    .OFF_DELAY(OFF_DELAY),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .x1       (x1),
    .x2       (x2),
    .lamp     (lamp),
    .count    (count),
    .full     (full),
    .empty    (empty),
    .enter_evt(enter_evt),
    .exit_evt (exit_evt),
    .ovf      (ovf),
    .unf      (unf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural room model ----------------
  int               pend [DOORS];  // +1 entering, -1 leaving, 0 nothing pending
  int               age  [DOORS];  // edges spent pending without resolution
  bit               lock [DOORS];  // must see both beams clear before reuse
  int               m_count;
  int               since_drop;    // edges since the room last became empty
  logic [DOORS-1:0] m_ent;
  logic [DOORS-1:0] m_ext;
  bit               m_ovf;
  bit               m_unf;

  task automatic model_reset();
    for (int d = 0; d < DOORS; d++) begin
      pend[d] = 0;
      age[d]  = 0;
      lock[d] = 1'b0;
    end
    m_count    = 0;
    since_drop = BIG;
    m_ent      = '0;
    m_ext      = '0;
    m_ovf      = 1'b0;
    m_unf      = 1'b0;
  endtask

  task automatic model_step();
    int c;
    int prev;
    bit far_b;
    bit near_b;
    m_ent = '0;
    m_ext = '0;
    m_ovf = 1'b0;
    m_unf = 1'b0;
    if (clr) begin
      for (int d = 0; d < DOORS; d++) begin
        pend[d] = 0;
        age[d]  = 0;
        lock[d] = 1'b1;
      end
      m_count    = 0;
      since_drop = BIG;
      return;
    end
    for (int d = 0; d < DOORS; d++) begin
      if (lock[d]) begin
        if (!x1[d] && !x2[d]) lock[d] = 1'b0;
      end else if (pend[d] == 0) begin
        if (x1[d] && !x2[d]) begin
          pend[d] = 1;
          age[d]  = 0;
        end else if (x2[d] && !x1[d]) begin
          pend[d] = -1;
          age[d]  = 0;
        end
      end else begin
        far_b  = (pend[d] > 0) ? x2[d] : x1[d];
        near_b = (pend[d] > 0) ? x1[d] : x2[d];
        if (far_b) begin
          if (pend[d] > 0) m_ent[d] = 1'b1;
          else             m_ext[d] = 1'b1;
          pend[d] = 0;
          lock[d] = 1'b1;
        end else if (!near_b) begin
          pend[d] = 0;
        end else begin
          age[d]++;
          if (age[d] >= TIMEOUT) begin
            pend[d] = 0;
            lock[d] = 1'b1;
          end
        end
      end
    end
    prev = m_count;
    c = prev - $countones(m_ext);
    if (c < 0) begin
      m_unf = 1'b1;
      c = 0;
    end
    c = c + $countones(m_ent);
    if (c > MAX_OCC) begin
      m_ovf = 1'b1;
      c = MAX_OCC;
    end
    m_count = c;
    if (c != 0)                 since_drop = BIG;
    else if (prev != 0)         since_drop = 0;
    else if (since_drop < BIG)  since_drop++;
  endtask

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else     model_step();
    end
  end

  // ---------------- per-cycle comparison against the model ----------------
  initial begin
    forever begin
      @(negedge clk);
      chk("count", int'(count), m_count);
      chk("full", int'(full), int'(m_count == MAX_OCC));
      chk("empty", int'(empty), int'(m_count == 0));
      chk("lamp", int'(lamp), int'((m_count != 0) || (since_drop < OFF_DELAY)));
      chk("enter_evt", int'(enter_evt), int'(m_ent));
      chk("exit_evt", int'(exit_evt), int'(m_ext));
      chk("ovf", int'(ovf), int'(m_ovf));
      chk("unf", int'(unf), int'(m_unf));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, expected finish before 2ms");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_door(input int d, input bit a, input bit b);
    x1[d] = a;
    x2[d] = b;
  endtask

  // Break x1 for n cycles, then x2; returns right after the counting edge
  task automatic entry(input int d, input int n);
    set_door(d, 1'b1, 1'b0);
    repeat (n) tick();
    set_door(d, 1'b1, 1'b1);
    tick();
  endtask

  task automatic leave(input int d, input int n);
    set_door(d, 1'b0, 1'b1);
    repeat (n) tick();
    set_door(d, 1'b1, 1'b1);
    tick();
  endtask

  task automatic release_all();
    x1 = '0;
    x2 = '0;
    tick();
  endtask

  initial begin
    model_reset();
    rst = 1'b1;
    clr = 1'b0;
    x1  = '0;
    x2  = '0;
    tick();
    tick();
    chk("rst_count", int'(count), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_full", int'(full), 0);
    chk("rst_lamp", int'(lamp), 0);
    rst = 1'b0;
    tick();

    // Single entry on door0
    entry(0, 2);
    chk("ent_evt", int'(enter_evt), 1);
    chk("ent_count", int'(count), 1);
    chk("ent_lamp", int'(lamp), 1);
    chk("ent_empty", int'(empty), 0);
    release_all();
    chk("ent_evt_drop", int'(enter_evt), 0);

    // Exit on door1 and lamp hold timing
    leave(1, 1);
    chk("ext_evt", int'(exit_evt), 2);
    chk("ext_count", int'(count), 0);
    chk("ext_empty", int'(empty), 1);
    chk("hold_lamp0", int'(lamp), 1);
    release_all();
    chk("hold_lamp1", int'(lamp), 1);
    tick();
    chk("hold_lamp2", int'(lamp), 1);
    tick();
    chk("hold_lamp3", int'(lamp), 0);

    // Entry during the hold keeps the lamp on
    entry(0, 1);
    release_all();
    leave(1, 1);
    set_door(1, 1'b0, 1'b0);
    set_door(0, 1'b1, 1'b0);
    tick();
    chk("rehold_lamp1", int'(lamp), 1);
    set_door(0, 1'b1, 1'b1);
    tick();
    chk("rehold_count", int'(count), 1);
    chk("rehold_lamp2", int'(lamp), 1);
    release_all();
    chk("rehold_lamp3", int'(lamp), 1);
    leave(1, 1);
    release_all();
    repeat (3) tick();
    chk("rehold_off", int'(lamp), 0);

    // Abort and timeout
    set_door(0, 1'b1, 1'b0);
    tick();
    set_door(0, 1'b0, 1'b0);
    tick();
    chk("abort_evt", int'(enter_evt), 0);
    chk("abort_count", int'(count), 0);
    set_door(0, 1'b1, 1'b0);
    repeat (9) tick();
    set_door(0, 1'b0, 1'b1);
    tick();
    set_door(0, 1'b1, 1'b1);
    tick();
    chk("tmo_enter", int'(enter_evt), 0);
    chk("tmo_exit", int'(exit_evt), 0);
    chk("tmo_unf", int'(unf), 0);
    chk("tmo_count", int'(count), 0);
    release_all();
    entry(0, 1);
    chk("tmo_recover", int'(count), 1);
    release_all();
    leave(1, 1);
    release_all();
    repeat (3) tick();

    // Ceiling and floor
    repeat (3) begin
      entry(0, 1);
      release_all();
    end
    chk("fill_count", int'(count), 3);
    chk("fill_full", int'(full), 1);
    entry(0, 1);
    chk("ovf_evt", int'(enter_evt), 1);
    chk("ovf_pulse", int'(ovf), 1);
    chk("ovf_count", int'(count), 3);
    chk("ovf_full", int'(full), 1);
    release_all();
    chk("ovf_drop", int'(ovf), 0);
    repeat (3) begin
      leave(1, 1);
      release_all();
    end
    leave(1, 1);
    chk("unf_evt", int'(exit_evt), 2);
    chk("unf_pulse", int'(unf), 1);
    chk("unf_count", int'(count), 0);
    release_all();
    chk("unf_drop", int'(unf), 0);

    // Simultaneous entry and exit
    repeat (2) begin
      entry(0, 1);
      release_all();
    end
    x1 = 2'b01;
    x2 = 2'b10;
    tick();
    x1 = 2'b11;
    x2 = 2'b11;
    tick();
    chk("sim2_enter", int'(enter_evt), 1);
    chk("sim2_exit", int'(exit_evt), 2);
    chk("sim2_count", int'(count), 2);
    release_all();
    entry(0, 1);
    release_all();
    x1 = 2'b01;
    x2 = 2'b10;
    tick();
    x1 = 2'b11;
    x2 = 2'b11;
    tick();
    chk("sim3_count", int'(count), 3);
    chk("sim3_ovf", int'(ovf), 0);
    chk("sim3_unf", int'(unf), 0);
    chk("sim3_enter", int'(enter_evt), 1);
    release_all();

    // Reset mid-crossing
    set_door(0, 1'b1, 1'b0);
    tick();
    rst = 1'b1;
    #1;
    chk("arst_count", int'(count), 0);
    chk("arst_lamp", int'(lamp), 0);
    chk("arst_empty", int'(empty), 1);
    tick();
    rst = 1'b0;
    set_door(0, 1'b1, 1'b1);
    tick();
    chk("arst_noevt", int'(enter_evt), 0);
    chk("arst_count2", int'(count), 0);
    set_door(0, 1'b0, 1'b1);
    tick();
    release_all();
    chk("arst_count3", int'(count), 0);

    // Clear with occupancy and a crossing completing on the same edge
    repeat (2) begin
      entry(0, 1);
      release_all();
    end
    chk("clr_pre_lamp", int'(lamp), 1);
    set_door(1, 1'b1, 1'b0);
    tick();
    clr = 1'b1;
    set_door(1, 1'b1, 1'b1);
    tick();
    chk("clr_count", int'(count), 0);
    chk("clr_lamp", int'(lamp), 0);
    chk("clr_empty", int'(empty), 1);
    chk("clr_noevt", int'(enter_evt), 0);
    clr = 1'b0;
    tick();
    chk("clr_lamp2", int'(lamp), 0);
    chk("clr_noevt2", int'(enter_evt), 0);
    release_all();
    tick();
    chk("clr_lamp3", int'(lamp), 0);

    // Randomized barrier activity with occasional clr and rst
    for (int n = 0; n < 3000; n++) begin
      for (int d = 0; d < DOORS; d++) begin
        if (n < 1500) begin
          if ($urandom_range(3) == 0) x1[d] = ~x1[d];
          if ($urandom_range(3) == 0) x2[d] = ~x2[d];
        end else begin
          if ($urandom_range(7) == 0) x1[d] = ~x1[d];
          if ($urandom_range(7) == 0) x2[d] = ~x2[d];
        end
      end
      clr = ($urandom_range(79) == 0);
      rst = ($urandom_range(499) == 0);
      tick();
    end
    rst = 1'b0;
    clr = 1'b0;
    release_all();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/occupancy_ctrl.md
OCCUPANCY_CTRL -- requirements
Module: occupancy_ctrl

Interface
REQ-001 The block SHALL have parameter DOORS, default 2, giving the number of doorways, each with two light barriers (legal 1..8).
REQ-002 The block SHALL have parameter CNT_W, default 8, giving the occupancy counter width.
REQ-003 The block SHALL have parameter MAX_OCC, default 200, giving the saturation ceiling (1..2^CNT_W-1).
REQ-004 The block SHALL have parameter OFF_DELAY, default 16, giving the number of lamp hold cycles after the room empties (0 legal).
REQ-005 The block SHALL have parameter TIMEOUT, default 1000, giving the maximum cycles a half-crossed door may stay pending.
REQ-006 The block SHALL have the following ports, clock and reset first:
clk  in  1  clock, all logic on rising edge
rst  in  1  reset, asynchronous, active-high
clr  in  1  synchronous clear of occupancy
x1  in  DOORS  outer barrier per door, high = beam broken, pre-synchronised
x2  in  DOORS  inner barrier per door, high = beam broken, pre-synchronised
lamp  out  1  room light
count  out  CNT_W  current occupancy
full  out  1  count == MAX_OCC
empty  out  1  count == 0
enter_evt  out  DOORS  one-cycle pulse per door, entry counted
exit_evt  out  DOORS  one-cycle pulse per door, exit counted
ovf  out  1  one-cycle pulse, at least one entry rejected at ceiling
unf  out  1  one-cycle pulse, at least one exit rejected at zero

Function
REQ-007 Each door SHALL have an independent registered FSM with states IDLE, IN_A (x1 first), OUT_B (x2 first) and WAIT.
REQ-008 IDLE SHALL go to IN_A on x1&!x2, to OUT_B on x2&!x1, and SHALL stay in IDLE on both or neither.
REQ-009 IN_A SHALL go to WAIT with an entry on x2, go to IDLE on !x1&!x2 (abort, no count), and otherwise stay.
REQ-010 OUT_B SHALL go to WAIT with an exit on x1, go to IDLE on !x1&!x2 (abort), and otherwise stay.
REQ-011 WAIT SHALL go to IDLE only when x1 and x2 are both low, and SHALL count nothing.
REQ-012 A per-door timer SHALL count cycles in IN_A/OUT_B; on reaching TIMEOUT the FSM SHALL go to WAIT with no count.
REQ-013 enter_evt[i]/exit_evt[i] SHALL be registered and high for exactly the one cycle following the edge at which the FSM leaves IN_A/OUT_B with a count.
REQ-014 Per edge, count SHALL update by E minus X, where E/X are the accepted entry/exit events across all doors that edge.
REQ-015 Events SHALL be applied as exits first, then entries; the result SHALL be clamped to 0..MAX_OCC.
REQ-016 Any clamped entry SHALL pulse ovf and any clamped exit SHALL pulse unf for one cycle; the evt pulses SHALL still assert.
REQ-017 count, full and empty SHALL be registered and reflect the same edge as the evt pulses (1-cycle latency from the sampled completing barrier).
REQ-018 The lamp SHALL be registered: lamp_next = (count_next != 0) | (hold_next != 0).
REQ-019 hold SHALL load OFF_DELAY at the edge where count goes from nonzero to 0, decrement to 0 each cycle, and clear when count becomes nonzero.
REQ-020 With OFF_DELAY=N>0, the lamp SHALL stay high for exactly N cycles after empty rises; with N=0, the lamp SHALL fall at the same edge as empty.
REQ-021 clr SHALL set count=0, hold=0, lamp=0, drive all door FSMs to WAIT, suppress that edge's events, and take priority over all events.

Reset
REQ-022 rst SHALL force count=0, empty=1, full=0, lamp=0, all evt/ovf/unf=0, hold=0, door timers=0 and all door FSMs=IDLE, asynchronously.
REQ-023 rst asserted mid-crossing SHALL discard the pending crossing, and no event SHALL follow deassertion until a fresh sequence completes.

Verification (DOORS=2, CNT_W=4, MAX_OCC=3, OFF_DELAY=3, TIMEOUT=8)
REQ-024 Stimulus: door0 x1=1 for 2 cycles, then x2=1, then both low. Required response: enter_evt[0] pulses once, count 0->1, lamp=1 the same cycle, empty=0.
REQ-025 Stimulus: with count=1, door1 performs an exit sequence. Required response: exit_evt[1] pulses, count=0, empty=1, lamp stays high 3 cycles and then goes 0; an entry during the hold keeps lamp high.
REQ-026 Stimulus: x1=1 then released with no x2, and separately x1 held 9 cycles. Required response: no evt and count unchanged; the timed-out door stays in WAIT until both barriers are low.
REQ-027 Stimulus: count=3 and an entry on door0. Required response: enter_evt[0] pulses, ovf pulses, count stays 3, full=1. Stimulus: count=0 and an exit. Required response: unf pulses, count stays 0.
REQ-028 Stimulus: count=2, door0 entry and door1 exit completing on the same edge. Required response: both evt pulses assert and count stays 2. Stimulus: count=3, same pattern. Required response: count 3, no ovf.
REQ-029 Stimulus: rst pulsed mid-crossing, and separately clr asserted with count=2 and lamp=1. Required response: count=0, lamp=0 immediately with no hold, and no event from the interrupted crossing.
